// File: rtl/sprite_draw.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_draw
//  Purpose  : CHIP-8 style sprite engine. It owns a 64x32 one-bit framebuffer
//             and runs two operations on it:
//               - DXYN draw: XORs N sprite bytes, fetched one per row from the
//                 attached memory, into the framebuffer. Pixels that fall off
//                 the right edge or the bottom edge are clipped. 'collision'
//                 reports whether any lit pixel was turned off.
//               - 00E0 clear: zeroes the framebuffer, one row per cycle.
//  Ports    : clk_in, rst_n_in     - clock / async active-low reset
//             start_draw/clear     - operation requests (sampled in IDLE)
//             sprite_addr, x_in,
//             y_in, rows_in        - draw arguments (sampled with the request)
//             mem_read_address     - registered memory read address
//             mem_data_in          - memory data, one cycle after the address
//             busy, done           - operation in progress / end pulse
//             collision            - VF result, held until the next start
//             fb_row_sel/out       - combinational display read port
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_draw #(
  parameter  int RAM_SIZE_BYTES = 4096,
  localparam int AW             = $clog2(RAM_SIZE_BYTES)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_draw,
  input  logic          start_clear,
  input  logic [AW-1:0] sprite_addr,
  input  logic [7:0]    x_in,
  input  logic [7:0]    y_in,
  input  logic [3:0]    rows_in,
  output logic [AW-1:0] mem_read_address,
  input  logic [7:0]    mem_data_in,
  output logic          busy,
  output logic          done,
  output logic          collision,
  input  logic [4:0]    fb_row_sel,
  output logic [63:0]   fb_row_out
);

  localparam logic [AW:0] RAM_SIZE = (AW+1)'(RAM_SIZE_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [63:0]   fb [32];
  logic [7:0]    x0;           // always < 64
  logic [7:0]    y0;           // always < 32
  logic [3:0]    n_rows;
  logic [AW-1:0] base;
  logic [4:0]    row_cnt;      // sprite row during draw, fb row during clear

  logic [4:0]    row_cnt_inc;
  logic [7:0]    draw_row;
  logic          last_row;
  logic [7:0]    sprite_rev;
  logic [63:0]   pixel_mask;
  logic [63:0]   cur_row;
  logic          hit;
  logic [AW:0]   addr_sum;
  logic [AW-1:0] addr_next;

  // Sprite bit 7 is the leftmost pixel, so bit-reverse the byte before
  // shifting it to x0. Bits shifted beyond position 63 are dropped, which is
  // exactly the right-edge clip (no horizontal wrap).
  for (genvar j = 0; j < 8; j++) begin : g_rev
    assign sprite_rev[j] = mem_data_in[7-j];
  end

  assign pixel_mask  = {56'd0, sprite_rev} << x0;
  assign row_cnt_inc = row_cnt + 5'd1;
  assign draw_row    = y0 + {3'd0, row_cnt};
  assign cur_row     = fb[draw_row[4:0]];
  assign hit         = |(cur_row & pixel_mask);
  // Stop after N rows, or after the row that lands on the bottom line.
  assign last_row    = (row_cnt_inc == {1'b0, n_rows}) || (draw_row == 8'd31);

  // Next fetch address, wrapped to the memory size (also for non power of 2).
  assign addr_sum    = {1'b0, base} + (AW+1)'(row_cnt_inc);
  assign addr_next   = (addr_sum >= RAM_SIZE) ? AW'(addr_sum - RAM_SIZE)
                                              : addr_sum[AW-1:0];

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fb_row_out = fb[fb_row_sel];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_clear)     state_next = CLEAR;
        else if (start_draw) state_next = (rows_in == 4'd0) ? DONE : FETCH;
      end
      CLEAR:   if (row_cnt == 5'd31) state_next = DONE;
      FETCH:   state_next = DRAW;
      DRAW:    state_next = last_row ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x0               <= '0;
      y0               <= '0;
      n_rows           <= '0;
      base             <= '0;
      row_cnt          <= '0;
      collision        <= 1'b0;
      mem_read_address <= '0;
      for (int i = 0; i < 32; i++) fb[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_clear) begin
            row_cnt   <= '0;
            collision <= 1'b0;
          end else if (start_draw) begin
            x0        <= x_in & 8'h3F;
            y0        <= y_in & 8'h1F;
            n_rows    <= rows_in;
            base      <= sprite_addr;
            row_cnt   <= '0;
            collision <= 1'b0;
            // The address register is loaded on entry to FETCH so the read
            // is presented for the whole FETCH cycle; N=0 issues no read.
            if (rows_in != 4'd0) mem_read_address <= sprite_addr;
          end
        end
        CLEAR: begin
          fb[row_cnt] <= '0;
          row_cnt     <= row_cnt_inc;
        end
        DRAW: begin
          fb[draw_row[4:0]] <= cur_row ^ pixel_mask;
          if (hit) collision <= 1'b1;
          row_cnt <= row_cnt_inc;
          if (!last_row) mem_read_address <= addr_next;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_draw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_draw
//  Purpose  : Self-checking bench for sprite_draw. Stimulus computes expected
//             results from a pixel-level framebuffer model and queues them;
//             a monitor compares done latency, collision and fetch addresses
//             as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_draw;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_draw = 1'b0;
  logic        start_clear = 1'b0;
  logic [11:0] sprite_addr = '0;
  logic [7:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic [3:0]  rows_in = '0;
  logic [11:0] mem_read_address;
  logic [7:0]  mem_data_in = '0;
  logic        busy;
  logic        done;
  logic        collision;
  logic [4:0]  fb_row_sel = '0;
  logic [63:0] fb_row_out;

  sprite_draw #(.RAM_SIZE_BYTES(4096)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_draw       (start_draw),
    .start_clear      (start_clear),
    .sprite_addr      (sprite_addr),
    .x_in             (x_in),
    .y_in             (y_in),
    .rows_in          (rows_in),
    .mem_read_address (mem_read_address),
    .mem_data_in      (mem_data_in),
    .busy             (busy),
    .done             (done),
    .collision        (collision),
    .fb_row_sel       (fb_row_sel),
    .fb_row_out       (fb_row_out)
  );

  initial forever #5 clk_in = ~clk_in;

  // Synchronous memory: data follows the address by one clock.
  logic [7:0] mem [4096];
  always @(posedge clk_in) mem_data_in <= mem[mem_read_address];

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int acc; int lat; bit coll; } exp_t;
  typedef struct { int cyc; logic [11:0] addr; } addr_t;
  exp_t  exp_q[$];
  addr_t addr_q[$];

  logic [63:0] mfb [32];       // reference framebuffer
  int pass_cnt = 0;
  int total_cnt = 0;
  int done_count = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fb_sweep(string name);
    int bad = -1;
    logic [63:0] bad_act = '0;
    for (int i = 0; i < 32; i++) begin
      fb_row_sel = 5'(i);
      #1;
      if (fb_row_out !== mfb[i] && bad < 0) begin
        bad = i;
        bad_act = fb_row_out;
      end
    end
    total_cnt++;
    if (bad < 0) pass_cnt++;
    else $display("FAIL %s row %0d: actual %h required %h", name, bad, bad_act, mfb[bad]);
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk_in);
    while (busy && g < 200) begin
      g++;
      @(negedge clk_in);
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Issue one operation, model its effect, and check busy length, held
  // collision and the resulting framebuffer once it has finished.
  task automatic do_op(bit clr, bit drw, int x, int y, int n, int base, bit poke);
    int x0, y0, e, lat, busy_exp, a, cnt, px;
    bit coll;
    logic [7:0] b;
    wait_idle();
    a = cyc + 1;
    coll = 0;
    if (clr) begin
      for (int i = 0; i < 32; i++) mfb[i] = '0;
      lat = 32;
      busy_exp = 33;
    end else begin
      x0 = x % 64;
      y0 = y % 32;
      e  = (n < 32 - y0) ? n : 32 - y0;
      for (int r = 0; r < e; r++) begin
        b = mem[(base + r) % 4096];
        addr_q.push_back('{a + 2*r, 12'((base + r) % 4096)});
        for (int j = 0; j < 8; j++) begin
          px = x0 + j;
          if (px < 64 && b[7-j]) begin
            if (mfb[y0+r][px]) coll = 1;
            mfb[y0+r][px] = ~mfb[y0+r][px];
          end
        end
      end
      lat = 2 * e;
      busy_exp = 2 * e + 1;
    end
    exp_q.push_back('{a, lat, coll});
    start_clear = clr;
    start_draw  = drw;
    x_in        = 8'(x);
    y_in        = 8'(y);
    rows_in     = 4'(n);
    sprite_addr = 12'(base);
    @(posedge clk_in);
    #1;
    start_clear = 1'b0;
    start_draw  = 1'b0;
    cnt = 0;
    @(negedge clk_in);
    while (busy && cnt < 200) begin
      cnt++;
      start_draw = (poke && cnt == 10);   // must be ignored while busy
      @(negedge clk_in);
    end
    start_draw = 1'b0;
    check("busy_cycles", 64'(cnt), 64'(busy_exp));
    check("collision_hold", 64'(collision), 64'(coll));
    fb_sweep("framebuffer");
  endtask

  // Monitor: compares whatever the DUT presents against the queued results.
  initial begin
    addr_t t;
    exp_t  e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
          t = addr_q.pop_front();
          check("fetch_addr", 64'(mem_read_address), 64'(t.addr));
        end
        if (done) begin
          done_count++;
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_done: actual done=1 required no pending op (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("done_latency", 64'(cyc - e.acc), 64'(e.lat));
            check("collision", 64'(collision), 64'(e.coll));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    bit c;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) mfb[i] = '0;
    mem[12'h000] = 8'hF0;
    for (int i = 0; i < 5; i++) mem[12'h100 + i] = 8'hFF;

    // Reset state, checked while reset is held.
    repeat (3) @(negedge clk_in);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_collision", 64'(collision), 0);
    check("reset_addr", 64'(mem_read_address), 0);
    fb_sweep("reset_fb");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Directed cases.
    do_op(0, 1, 0, 0, 1, 12'h000, 0);     // 0xF0 at origin
    do_op(0, 1, 0, 0, 1, 12'h000, 0);     // same again: erase + collision
    do_op(0, 1, 60, 31, 5, 12'h100, 0);   // right and bottom clip
    do_op(0, 1, 70, 40, 2, 12'hFFF, 0);   // coordinate wrap, address wrap
    do_op(0, 1, 10, 5, 3, 12'h200, 0);    // more pixels before the clear
    do_op(1, 1, 0, 0, 4, 12'h000, 1);     // clear wins; mid-clear draw ignored
    do_op(0, 1, 20, 20, 0, 12'h300, 0);   // N=0: no fetch, done in cycle 1

    // Randomized operations.
    for (int i = 0; i < 25; i++) begin
      c = ($urandom_range(0, 5) == 0);
      do_op(c, !c || ($urandom_range(0, 1) == 1), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 15),
            $urandom_range(0, 4095), 0);
    end

    // Make sure the framebuffer is populated, then reset mid-draw.
    do_op(0, 1, 8, 2, 4, 12'h100, 0);
    wait_idle();
    start_draw  = 1'b1;
    x_in        = 8'd5;
    y_in        = 8'd3;
    rows_in     = 4'd15;
    sprite_addr = 12'h123;
    @(posedge clk_in);
    #1;
    start_draw = 1'b0;
    repeat (4) @(negedge clk_in);         // cycle 4 after accept: DRAW
    rst_n_in = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mfb[i] = '0;
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_collision", 64'(collision), 0);
    check("abort_addr", 64'(mem_read_address), 0);
    fb_sweep("abort_fb");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    dc = done_count;
    repeat (40) @(negedge clk_in);
    check("abort_no_done", 64'(done_count), 64'(dc));
    check("abort_idle", 64'(busy), 0);

    check("queues_drained", 64'(exp_q.size() + addr_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
